// File: rtl/audio_dac_pkg.sv
// Shared constants and types for the I2S DAC streamer.
// The I2S frame is fixed at 32 bit-clock slots, which ties DATA_W to 16 bits.
package audio_dac_pkg;

   localparam int unsigned DATA_W       = 16;
   localparam int unsigned FRAME_SLOTS  = 32;
   localparam int unsigned SLOT_W       = $clog2(FRAME_SLOTS);
   localparam int unsigned LOAD_SLOT    = 1;
   localparam int unsigned BCK_HALF_DEF = 6;

   typedef struct packed {
      logic [DATA_W-1:0] left;
      logic [DATA_W-1:0] right;
   } sample_pair_t;

endpackage

// File: rtl/sample_fifo.sv
// Synchronous first-word fall-through FIFO of stereo sample pairs.
// Pushes are dropped when full; pops are ignored when empty.
module sample_fifo
   import audio_dac_pkg::*;
#(
   parameter int unsigned DEPTH = 64
) (
   input  logic                   i_clk,
   input  logic                   i_rst,
   input  logic                   i_push,
   input  sample_pair_t           i_wr_data,
   input  logic                   i_pop,
   output sample_pair_t           o_rd_data,
   output logic [$clog2(DEPTH):0] o_level,
   output logic                   o_empty,
   output logic                   o_full
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned LVL_W = PTR_W + 1;

   sample_pair_t     r_mem [DEPTH];
   logic [PTR_W-1:0] r_wr_ptr;
   logic [PTR_W-1:0] r_rd_ptr;
   logic [LVL_W-1:0] r_level;
   logic             w_push;
   logic             w_pop;

   assign o_empty   = (r_level == '0);
   assign o_full    = (r_level == LVL_W'(DEPTH));
   assign o_level   = r_level;
   assign o_rd_data = r_mem[r_rd_ptr];
   assign w_push    = i_push & ~o_full;
   assign w_pop     = i_pop & ~o_empty;

   // Storage carries no reset; stale entries are unreachable once pointers clear.
   always_ff @(posedge i_clk) begin
      if (w_push) begin
         r_mem[r_wr_ptr] <= i_wr_data;
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_level  <= '0;
      end else begin
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + PTR_W'(1);
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + PTR_W'(1);
         end
         unique case ({w_push, w_pop})
            2'b10:   r_level <= r_level + LVL_W'(1);
            2'b01:   r_level <= r_level - LVL_W'(1);
            default: r_level <= r_level;
         endcase
      end
   end

endmodule

// File: rtl/i2s_dac_streamer.sv
// I2S master that plays buffered stereo PCM pairs to the codec DAC.
// Bit clock, slot counter and shift register all advance from one iCLK domain.
module i2s_dac_streamer
   import audio_dac_pkg::*;
#(
   parameter int unsigned FIFO_DEPTH = 64,
   parameter int unsigned BCK_HALF   = BCK_HALF_DEF
) (
   input  logic                        iCLK,
   input  logic                        iRST,
   input  logic [DATA_W-1:0]           iL_DATA,
   input  logic [DATA_W-1:0]           iR_DATA,
   input  logic                        iVALID,
   output logic                        oREADY,
   input  logic                        iCLR_UNDERRUN,
   output logic                        oUNDERRUN,
   output logic [$clog2(FIFO_DEPTH):0] oFIFO_LEVEL,
   output logic                        oAUD_BCK,
   output logic                        oAUD_LRCK,
   output logic                        oAUD_DATA
);

   localparam int unsigned DIV_W = (BCK_HALF > 1) ? $clog2(BCK_HALF) : 1;

   logic [DIV_W-1:0]    r_div;
   logic                r_bck;
   logic [SLOT_W-1:0]   r_slot;
   logic [2*DATA_W-1:0] r_sr;
   logic                r_underrun;

   logic                w_div_wrap;
   logic                w_bck_fall;
   logic [SLOT_W-1:0]   w_slot_next;
   logic                w_load;
   logic                w_empty;
   logic                w_full;
   sample_pair_t        w_head;
   sample_pair_t        w_wr_data;

   assign w_div_wrap  = (r_div == DIV_W'(BCK_HALF - 1));
   assign w_bck_fall  = w_div_wrap & r_bck;
   assign w_slot_next = r_slot + SLOT_W'(1);
   assign w_load      = w_bck_fall & (w_slot_next == SLOT_W'(LOAD_SLOT));
   assign w_wr_data   = '{left: iL_DATA, right: iR_DATA};

   sample_fifo #(
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .i_clk     (iCLK),
      .i_rst     (iRST),
      .i_push    (iVALID),
      .i_wr_data (w_wr_data),
      .i_pop     (w_load),
      .o_rd_data (w_head),
      .o_level   (oFIFO_LEVEL),
      .o_empty   (w_empty),
      .o_full    (w_full)
   );

   always_ff @(posedge iCLK) begin
      if (iRST) begin
         r_div      <= '0;
         r_bck      <= 1'b0;
         r_slot     <= '0;
         r_sr       <= '0;
         r_underrun <= 1'b0;
      end else begin
         if (w_div_wrap) begin
            r_div <= '0;
            r_bck <= ~r_bck;
         end else begin
            r_div <= r_div + DIV_W'(1);
         end
         // Data moves only on BCLK falling edges so the codec samples it on the rise.
         if (w_bck_fall) begin
            r_slot <= w_slot_next;
            if (w_load) begin
               r_sr <= w_empty ? '0 : w_head;
            end else begin
               r_sr <= {r_sr[2*DATA_W-2:0], 1'b0};
            end
         end
         if (w_load && w_empty) begin
            r_underrun <= 1'b1;
         end else if (iCLR_UNDERRUN) begin
            r_underrun <= 1'b0;
         end
      end
   end

   assign oREADY    = ~w_full;
   assign oUNDERRUN = r_underrun;
   assign oAUD_BCK  = r_bck;
   assign oAUD_LRCK = r_slot[SLOT_W-1];
   assign oAUD_DATA = r_sr[2*DATA_W-1];

endmodule

// File: tb/tb_i2s_dac_streamer.sv
// Randomised bench for i2s_dac_streamer, checked every cycle against a
// time-indexed model of the I2S frame and a queue model of the sample FIFO.
module tb_i2s_dac_streamer;

   logic        iCLK = 1'b0;
   logic        iRST = 1'b1;
   logic [15:0] iL_DATA = '0;
   logic [15:0] iR_DATA = '0;
   logic        iVALID = 1'b0;
   logic        iCLR_UNDERRUN = 1'b0;
   logic        oREADY;
   logic        oUNDERRUN;
   logic [6:0]  oFIFO_LEVEL;
   logic        oAUD_BCK;
   logic        oAUD_LRCK;
   logic        oAUD_DATA;

   int n_tests = 0;
   int n_fail  = 0;

   // Model state: t = edges since reset release, q = stored pairs, cur = pair being played.
   int          t = 0;
   logic [31:0] q[$];
   logic [31:0] cur = '0;
   logic        und = 1'b0;

   i2s_dac_streamer #(
      .FIFO_DEPTH (64),
      .BCK_HALF   (6)
   ) dut (
      .iCLK          (iCLK),
      .iRST          (iRST),
      .iL_DATA       (iL_DATA),
      .iR_DATA       (iR_DATA),
      .iVALID        (iVALID),
      .oREADY        (oREADY),
      .iCLR_UNDERRUN (iCLR_UNDERRUN),
      .oUNDERRUN     (oUNDERRUN),
      .oFIFO_LEVEL   (oFIFO_LEVEL),
      .oAUD_BCK      (oAUD_BCK),
      .oAUD_LRCK     (oAUD_LRCK),
      .oAUD_DATA     (oAUD_DATA)
   );

   always #5 iCLK = ~iCLK;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0d)", tag, obs, exp, t);
      end
   endtask

   task automatic model_edge(input logic rst, input logic vld, input logic [31:0] pair,
                             input logic clr);
      logic empty_pre;
      logic full_pre;
      logic load;
      if (rst) begin
         t   = 0;
         q.delete();
         cur = '0;
         und = 1'b0;
      end else begin
         empty_pre = (q.size() == 0);
         full_pre  = (q.size() >= 64);
         t++;
         load = (t % 384 == 12);
         if (load && !empty_pre) cur = q.pop_front();
         else if (load) cur = '0;
         if (load && empty_pre) und = 1'b1;
         else if (clr) und = 1'b0;
         if (vld && !full_pre) q.push_back(pair);
      end
   endtask

   task automatic check_outputs();
      int s;
      int idx;
      s   = (t / 12) % 32;
      idx = (s == 0) ? 0 : 32 - s;
      check_val("bck", 32'(oAUD_BCK), 32'((t / 6) % 2));
      check_val("lrck", 32'(oAUD_LRCK), 32'(s >= 16));
      check_val("data", 32'(oAUD_DATA), 32'(cur[idx]));
      check_val("level", 32'(oFIFO_LEVEL), 32'(q.size()));
      check_val("ready", 32'(oREADY), 32'(q.size() != 64));
      check_val("underrun", 32'(oUNDERRUN), 32'(und));
   endtask

   task automatic step(input logic rst, input logic vld, input logic [31:0] pair,
                       input logic clr);
      iRST          = rst;
      iVALID        = vld;
      iL_DATA       = pair[31:16];
      iR_DATA       = pair[15:0];
      iCLR_UNDERRUN = clr;
      @(posedge iCLK);
      model_edge(rst, vld, pair, clr);
      #1;
      check_outputs();
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 1'b0, $urandom, 1'b0);
   endtask

   task automatic do_reset();
      for (int i = 0; i < 3; i++) step(1'b1, $urandom_range(0, 1), $urandom, 1'b0);
   endtask

   initial begin
      logic [31:0] bits;

      // Reset values and bit-clock phase
      do_reset();
      check_val("rst_level", 32'(oFIFO_LEVEL), 32'd0);
      check_val("rst_ready", 32'(oREADY), 32'd1);
      idle(5);
      check_val("bck_e5", 32'(oAUD_BCK), 32'd0);
      idle(1);
      check_val("bck_e6", 32'(oAUD_BCK), 32'd1);
      idle(6);
      check_val("bck_e12", 32'(oAUD_BCK), 32'd0);

      // One pair played MSB-first with one-bit delay
      do_reset();
      step(1'b0, 1'b1, 32'hA5F0_0F0F, 1'b0);
      idle(10);
      check_val("lvl_pre_load", 32'(oFIFO_LEVEL), 32'd1);
      idle(1);
      check_val("lvl_post_load", 32'(oFIFO_LEVEL), 32'd0);
      bits = '0;
      while (t < 390) begin
         idle(1);
         if (t % 12 == 6 && t > 12) bits[32 - (t - 6) / 12] = oAUD_DATA;
      end
      check_val("frame_bits", bits, 32'hA5F0_0F0F);
      check_val("no_underrun", 32'(oUNDERRUN), 32'd0);

      // Underrun set, clear, and set-beats-clear
      do_reset();
      idle(12);
      check_val("und_first_load", 32'(oUNDERRUN), 32'd1);
      idle(50);
      step(1'b0, 1'b0, '0, 1'b1);
      check_val("und_cleared", 32'(oUNDERRUN), 32'd0);
      while (t < 395) idle(1);
      check_val("und_before_396", 32'(oUNDERRUN), 32'd0);
      idle(1);
      check_val("und_at_396", 32'(oUNDERRUN), 32'd1);
      while (t < 779) step(1'b0, 1'b0, '0, t < 500);
      step(1'b0, 1'b0, '0, 1'b1);
      check_val("und_set_wins", 32'(oUNDERRUN), 32'd1);

      // Fill to 64, drop the 65th, then random traffic long enough to wrap pointers
      do_reset();
      idle(12);
      for (int i = 0; i < 65; i++) step(1'b0, 1'b1, $urandom, 1'b0);
      check_val("full_level", 32'(oFIFO_LEVEL), 32'd64);
      check_val("full_ready", 32'(oREADY), 32'd0);
      for (int i = 0; i < 66 * 384; i++) begin
         step(1'b0, $urandom_range(0, 383) == 0, $urandom, $urandom_range(0, 1999) == 0);
      end

      // Push coinciding with a load at level 1
      do_reset();
      step(1'b0, 1'b1, $urandom, 1'b0);
      idle(10);
      step(1'b0, 1'b1, 32'h1234_8765, 1'b0);
      check_val("collide_level", 32'(oFIFO_LEVEL), 32'd1);
      idle(800);

      // Reset in slot 20 with entries queued
      do_reset();
      idle(12);
      for (int i = 0; i < 10; i++) step(1'b0, 1'b1, $urandom, 1'b0);
      while (t < 245) idle(1);
      step(1'b1, 1'b0, '0, 1'b0);
      check_val("midrst_level", 32'(oFIFO_LEVEL), 32'd0);
      check_val("midrst_lrck", 32'(oAUD_LRCK), 32'd0);
      check_val("midrst_data", 32'(oAUD_DATA), 32'd0);
      step(1'b0, 1'b1, 32'hC3C3_5A5A, 1'b0);
      idle(11);
      check_val("midrst_reload", 32'(oAUD_DATA), 32'd1);
      idle(400);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
